// File: rtl/divider_controller.sv
// divider_controller: sequences an iterative RV32M divider for DIV/DIVU/REM/REMU.
// Resolves divide-by-zero and signed overflow locally, and reuses the last divider result for a matching operand pair.
module divider_controller #(
    parameter int TAG_W    = 5,
    parameter bit CACHE_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             div_start,
    output logic             div_sign,
    output logic [31:0]      div_divident,
    output logic [31:0]      div_divisor,
    input  logic             div_busy,
    input  logic [31:0]      div_quotient,
    input  logic [31:0]      div_remainder
);
    typedef enum logic [2:0] {IDLE, START, WAIT, DRAIN, RESP} state_t;
    state_t state, state_nx;
    logic [1:0] op_q;
    logic busy_q, c_valid, c_sign;
    logic [31:0] c_rs1, c_rs2, c_q, c_r, fast_result;
    logic accept, sign, by_zero, ovf, special, hit, done;
    always_comb begin
        accept      = req_valid & req_ready;
        sign        = ~req_op[0];
        by_zero     = req_rs2 == 32'h0;
        ovf         = sign & (req_rs1 == 32'h8000_0000) & (req_rs2 == 32'hFFFF_FFFF);
        special     = by_zero | ovf;
        hit         = CACHE_EN & c_valid & (req_rs1 == c_rs1) & (req_rs2 == c_rs2) & (sign == c_sign);
        fast_result = by_zero ? (req_op[1] ? req_rs1 : 32'hFFFF_FFFF) :
                      ovf     ? (req_op[1] ? 32'h0 : 32'h8000_0000) :
                                (req_op[1] ? c_r : c_q);
        done        = busy_q & ~div_busy;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // A flush that coincides with completion goes straight to IDLE: DRAIN would never see another falling edge.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (special | hit) ? RESP : START;
            START:   state_nx = flush ? DRAIN : WAIT;
            WAIT:    state_nx = done ? (flush ? IDLE : RESP) : (flush ? DRAIN : WAIT);
            DRAIN:   if (done) state_nx = IDLE;
            RESP:    if (flush | resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        req_ready  = (state == IDLE) & ~flush;
        resp_valid = state == RESP;
        div_start  = state == START;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q       <= 1'b0;
            op_q         <= 2'b0;
            resp_tag     <= '0;
            resp_result  <= 32'h0;
            div_sign     <= 1'b0;
            div_divident <= 32'h0;
            div_divisor  <= 32'h0;
            c_valid      <= 1'b0;
            c_sign       <= 1'b0;
            c_rs1        <= 32'h0;
            c_rs2        <= 32'h0;
            c_q          <= 32'h0;
            c_r          <= 32'h0;
        end else begin
            busy_q <= div_busy;
            if (accept) begin
                op_q     <= req_op;
                resp_tag <= req_tag;
            end
            if (accept & (special | hit))
                resp_result <= fast_result;
            // Divider operands only move when a new run starts, so they stay put while it iterates.
            if (accept & ~special & ~hit) begin
                div_sign     <= sign;
                div_divident <= req_rs1;
                div_divisor  <= req_rs2;
            end
            if ((state == WAIT) & done & ~flush)
                resp_result <= op_q[1] ? div_remainder : div_quotient;
            if (flush)
                c_valid <= 1'b0;
            else if ((state == WAIT) & done) begin
                c_valid <= 1'b1;
                c_sign  <= div_sign;
                c_rs1   <= div_divident;
                c_rs2   <= div_divisor;
                c_q     <= div_quotient;
                c_r     <= div_remainder;
            end
        end
    end
endmodule
